decode_2_4_hold_seq: RTL

- Sequential counterpart to the team's 4x2 priority encoders. Consumes the encoder's {V,Y} code and drives a registered one-hot 4-bit select D.
- Each accepted code holds D for HOLD_CYCLES cycles, then forces a GAP_CYCLES all-zero dead time before the next code can be accepted.
- Sits downstream of the priority encoder and drives one-hot enables (e.g. channel grants) that must be glitch-free and time-bounded.

---
 rtl/decode_2_4_hold_seq_pkg.sv | 23 ++
 rtl/decode_2_4_df.sv | 16 +
 rtl/decode_2_4_hold_seq.sv | 94 +++++++++
 3 files changed

// File: rtl/decode_2_4_hold_seq_pkg.sv
// Shared definitions for the 2-to-4 hold sequencer: state encoding and a reusable one-hot decode.
package decode_2_4_hold_seq_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned ONEHOT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // 2-to-4 one-hot decode; a low enable forces zero even when sel is unknown.
    function automatic logic [ONEHOT_W-1:0] dec_2_4(input logic [SEL_W-1:0] sel, input logic en);
        logic [ONEHOT_W-1:0] res;
        res[0] = en & ~sel[1] & ~sel[0];
        res[1] = en & ~sel[1] &  sel[0];
        res[2] = en &  sel[1] & ~sel[0];
        res[3] = en &  sel[1] &  sel[0];
        return res;
    endfunction

endpackage

// File: rtl/decode_2_4_df.sv
// Combinational dataflow 2-to-4 decoder with enable.
module decode_2_4_df
    import decode_2_4_hold_seq_pkg::*;
(
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [ONEHOT_W-1:0] dec
);

    // Enable is ANDed into every term, so an unknown sel with en=0 still yields zero.
    assign dec[0] = en & ~sel[1] & ~sel[0];
    assign dec[1] = en & ~sel[1] &  sel[0];
    assign dec[2] = en &  sel[1] & ~sel[0];
    assign dec[3] = en &  sel[1] &  sel[0];

endmodule

// File: rtl/decode_2_4_hold_seq.sv
// Accepts an encoder {V,Y} code, holds a registered one-hot select for HOLD_CYCLES,
// then enforces GAP_CYCLES of dead time before the next code.
module decode_2_4_hold_seq
    import decode_2_4_hold_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    Y,
    input  logic                V,
    input  logic                CLR,
    output logic                RDY,
    output logic [ONEHOT_W-1:0] D,
    output logic                BUSY,
    output logic                DONE,
    output logic                OVF
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ONEHOT_W-1:0] dec;

    decode_2_4_df u_dec (
        .en  (V),
        .sel (Y),
        .dec (dec)
    );

    // Handshake flags come straight from the state register, never from inputs.
    assign RDY  = (state == ST_IDLE);
    assign BUSY = ~RDY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            D     <= '0;
            DONE  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            DONE <= 1'b0;

            // A code offered while busy is lost; the set term wins over CLR.
            if (V && !RDY) begin
                OVF <= 1'b1;
            end else if (CLR) begin
                OVF <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (V) begin
                        D     <= dec;
                        cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        state <= ST_HOLD;
                    end else begin
                        D <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        D    <= '0;
                        DONE <= 1'b1;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                            state <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    D <= '0;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    D     <= '0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
